dma_grant_dispatcher: RTL and testbench
=======================================

Name: dma_grant_dispatcher

Overview:
- Sits directly downstream of the DMA channel round-robin arbiter (registered one-hot grant plus grantAck protocol).
- Turns each arbiter grant into a transfer command by selecting the granted channel's descriptor (src, dst, length) and pushing it into a small command queue that feeds the AXI transfer engine.
- Tracks per-channel in-flight status and masks busy channels out of the arbiter request vector.
- Returns completion pulses to the channels.

Parameters:
NO_OF_CHANNELS, 4, number of requesting channels (2..16)
CID_WIDTH, 2, channel id width, ceil(log2(NO_OF_CHANNELS))
ADDR_WIDTH, 32, source/destination address width
LEN_WIDTH, 23, transfer length width (bytes)
FIFO_DEPTH, 2, command queue depth (power of 2, >=2)

Ports:
clock  input  1  clock
resetn  input  1  asynchronous active-low reset
chReq  input  NO_OF_CHANNELS  level request per channel, held until chDone
chSrcAddr  input  NO_OF_CHANNELS*ADDR_WIDTH  per-channel source address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
chDstAddr  input  NO_OF_CHANNELS*ADDR_WIDTH  per-channel destination address, same packing
chLen  input  NO_OF_CHANNELS*LEN_WIDTH  per-channel length, same packing
arbReq  output  NO_OF_CHANNELS  request vector to arbiter
arbGrant  input  NO_OF_CHANNELS  registered one-hot grant from arbiter
arbGrantAck  output  1  grant consumed
cmdValid  output  1  command available
cmdReady  input  1  transfer engine accepts command
cmdChanId  output  CID_WIDTH  command channel id
cmdSrcAddr  output  ADDR_WIDTH  command source address
cmdDstAddr  output  ADDR_WIDTH  command destination address
cmdLen  output  LEN_WIDTH  command length
cmdDone  input  1  one-cycle completion pulse from engine
cmdDoneChanId  input  CID_WIDTH  id of completed command
chStart  output  NO_OF_CHANNELS  one-cycle pulse: channel command queued
chDone  output  NO_OF_CHANNELS  one-cycle pulse: channel transfer finished
grantErr  output  1  one-cycle pulse: non-one-hot grant seen
doneErr  output  1  one-cycle pulse: cmdDone for a non-in-flight channel

Behaviour:
- Reset (async, resetn low):
  - Queue empty, count 0; inFlight all 0.
  - cmdValid 0; cmdChanId, cmdSrcAddr, cmdDstAddr and cmdLen all 0.
  - chStart, chDone, grantErr and doneErr all 0.
  - Reset mid-operation discards queued commands without pulses.
- arbReq = chReq & ~inFlight & ~arbGrant (combinational). Masking the held grant stops the arbiter re-granting the channel being acked.
- arbGrantAck = (|arbGrant) & ~full (combinational, from registered signals only; no loop through the arbiter).
- Ack cycle T, one-hot grant for channel k:
  - Descriptor k is written into the queue at the T edge, with chanId=k.
  - inFlight[k] is set at the T edge.
  - chStart[k] pulses in T+1.
  - When the queue was empty, cmdValid rises in T+1 (latency 1).
- Zero length (chLen[k]==0) at ack:
  - Nothing is queued and inFlight is not set.
  - chStart[k] and chDone[k] both pulse in T+1.
- Non-one-hot grant at ack: acked and dropped, nothing queued, grantErr pulses in T+1.
- Queue full: arbGrantAck held 0 and the grant waits (the arbiter holds it). Push only when not full, so there is no push-when-full case.
- Queue and command interface:
  - Pop on cmdValid & cmdReady.
  - Command fields are the head entry and stay stable while cmdValid=1 and cmdReady=0.
  - Simultaneous push and pop when not full: count unchanged, ordering FIFO.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Count width is log2(FIFO_DEPTH)+1.
- cmdDone with inFlight[id]=1: clears inFlight[id] at the edge, chDone[id] pulses next cycle.
- cmdDone with inFlight[id]=0 (or id >= NO_OF_CHANNELS): ignored, doneErr pulses next cycle.
- Set and spurious done in the same cycle for the same channel: set wins and doneErr pulses.
- Multiple channels may be in flight, up to NO_OF_CHANNELS. A channel has at most one outstanding command.

Test Plan:
1. Reset, then chReq=4'b0101, chLen nonzero, cmdReady=1 → arbReq=4'b0101. Command for ch0 then ch2, each cmdValid 1 cycle after its ack. chStart[0] then chStart[2]. arbReq ends 4'b0000.
2. cmdReady=0, all four channels request, FIFO_DEPTH=2 → two acks, then arbGrantAck=0 with the grant held. Raise cmdReady for one cycle → third ack the same cycle after the pop. Command order 0,1,2.
3. ch1 in flight, cmdDone with id=1 → chDone[1] pulses next cycle and arbReq[1] reasserts while chReq[1]=1. Repeat cmdDone id=1 → doneErr pulse, no chDone.
4. chLen[3]=0 with a grant on ch3 → ack, no cmdValid, chStart[3] and chDone[3] pulse together, inFlight[3]=0.
5. Force arbGrant=4'b0011 → ack, no push, grantErr pulse. Async resetn low while 2 commands are queued → cmdValid=0 immediately and inFlight cleared.

Source files
------------

// File: rtl/dma_grant_dispatcher.sv
// rtl/dma_grant_dispatcher.sv - turns arbiter grants into queued DMA transfer commands
//
// Ports:
//   clock, resetn                 clock and asynchronous active-low reset
//   chReq                         per-channel level request, held until chDone
//   chSrcAddr/chDstAddr/chLen     packed per-channel descriptors, channel i at [i*W +: W]
//   arbReq                        request vector to the arbiter, busy/granted channels masked
//   arbGrant, arbGrantAck         registered one-hot grant in, grant-consumed out
//   cmdValid/cmdReady             command queue head handshake toward the transfer engine
//   cmdChanId/Src/Dst/Len         head command fields (zero while the queue is empty)
//   cmdDone, cmdDoneChanId        completion pulse and channel id from the engine
//   chStart, chDone               per-channel one-cycle pulses
//   grantErr, doneErr             one-cycle error pulses

module dma_grant_dispatcher #(
    parameter int NO_OF_CHANNELS = 4,
    parameter int CID_WIDTH      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 23,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                                clock,
    input  logic                                resetn,
    input  logic [NO_OF_CHANNELS-1:0]           chReq,
    input  logic [NO_OF_CHANNELS*ADDR_WIDTH-1:0] chSrcAddr,
    input  logic [NO_OF_CHANNELS*ADDR_WIDTH-1:0] chDstAddr,
    input  logic [NO_OF_CHANNELS*LEN_WIDTH-1:0]  chLen,
    output logic [NO_OF_CHANNELS-1:0]           arbReq,
    input  logic [NO_OF_CHANNELS-1:0]           arbGrant,
    output logic                                arbGrantAck,
    output logic                                cmdValid,
    input  logic                                cmdReady,
    output logic [CID_WIDTH-1:0]                cmdChanId,
    output logic [ADDR_WIDTH-1:0]               cmdSrcAddr,
    output logic [ADDR_WIDTH-1:0]               cmdDstAddr,
    output logic [LEN_WIDTH-1:0]                cmdLen,
    input  logic                                cmdDone,
    input  logic [CID_WIDTH-1:0]                cmdDoneChanId,
    output logic [NO_OF_CHANNELS-1:0]           chStart,
    output logic [NO_OF_CHANNELS-1:0]           chDone,
    output logic                                grantErr,
    output logic                                doneErr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NO_OF_CHANNELS-1:0] in_flight;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;

    logic [CID_WIDTH-1:0]  mem_cid [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_src [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_dst [FIFO_DEPTH];
    logic [LEN_WIDTH-1:0]  mem_len [FIFO_DEPTH];

    logic                      full;
    logic                      empty;
    logic                      ack;
    logic                      grant_onehot;
    logic [CID_WIDTH-1:0]      grant_id;
    logic [ADDR_WIDTH-1:0]     sel_src;
    logic [ADDR_WIDTH-1:0]     sel_dst;
    logic [LEN_WIDTH-1:0]      sel_len;
    logic                      zero_len;
    logic                      push;
    logic                      pop;
    logic [NO_OF_CHANNELS-1:0] set_mask;
    logic [NO_OF_CHANNELS-1:0] done_hit;
    logic [NO_OF_CHANNELS-1:0] zero_done;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

    // Ack depends only on the registered grant and queue state, so there is
    // no combinational path back into the arbiter.
    assign arbGrantAck = (|arbGrant) & ~full;
    assign ack         = arbGrantAck;

    // The held grant is masked so the arbiter cannot re-grant the channel
    // whose grant is still being consumed.
    assign arbReq = chReq & ~in_flight & ~arbGrant;

    assign grant_onehot = (arbGrant != '0) &&
                          ((arbGrant & (arbGrant - NO_OF_CHANNELS'(1))) == '0);

    // OR-mux of the descriptors; only meaningful when the grant is one-hot.
    always_comb begin
        grant_id = '0;
        sel_src  = '0;
        sel_dst  = '0;
        sel_len  = '0;
        for (int i = 0; i < NO_OF_CHANNELS; i++) begin
            if (arbGrant[i]) begin
                grant_id = grant_id | CID_WIDTH'(i);
                sel_src  = sel_src | chSrcAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_dst  = sel_dst | chDstAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = sel_len | chLen[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    assign zero_len  = (sel_len == '0);
    assign push      = ack & grant_onehot & ~zero_len;
    assign pop       = cmdValid & cmdReady;
    assign set_mask  = push ? arbGrant : '0;
    assign zero_done = (ack & grant_onehot & zero_len) ? arbGrant : '0;

    // Out-of-range ids never match any channel and fall through to doneErr.
    always_comb begin
        done_hit = '0;
        for (int i = 0; i < NO_OF_CHANNELS; i++) begin
            done_hit[i] = cmdDone && (cmdDoneChanId == CID_WIDTH'(i)) && in_flight[i];
        end
    end

    assign cmdValid   = ~empty;
    assign cmdChanId  = empty ? '0 : mem_cid[rd_ptr];
    assign cmdSrcAddr = empty ? '0 : mem_src[rd_ptr];
    assign cmdDstAddr = empty ? '0 : mem_dst[rd_ptr];
    assign cmdLen     = empty ? '0 : mem_len[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem_cid[wr_ptr] <= grant_id;
            mem_src[wr_ptr] <= sel_src;
            mem_dst[wr_ptr] <= sel_dst;
            mem_len[wr_ptr] <= sel_len;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_flight <= '0;
            chStart   <= '0;
            chDone    <= '0;
            grantErr  <= 1'b0;
            doneErr   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Set is applied after clear so a same-cycle set wins.
            in_flight <= (in_flight & ~done_hit) | set_mask;
            chStart   <= (ack && grant_onehot) ? arbGrant : '0;
            chDone    <= done_hit | zero_done;
            grantErr  <= ack & ~grant_onehot;
            doneErr   <= cmdDone & ~(|done_hit);
        end
    end

endmodule

// File: tb/tb_dma_grant_dispatcher.sv
// tb/tb_dma_grant_dispatcher.sv - self-checking bench for dma_grant_dispatcher

module tb_dma_grant_dispatcher;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int AW = 32;
    localparam int LW = 23;
    localparam int FD = 2;

    logic              clock;
    logic              resetn;
    logic [N-1:0]      chReq;
    logic [N*AW-1:0]   chSrcAddr;
    logic [N*AW-1:0]   chDstAddr;
    logic [N*LW-1:0]   chLen;
    logic [N-1:0]      arbReq;
    logic [N-1:0]      arbGrant;
    logic              arbGrantAck;
    logic              cmdValid;
    logic              cmdReady;
    logic [CW-1:0]     cmdChanId;
    logic [AW-1:0]     cmdSrcAddr;
    logic [AW-1:0]     cmdDstAddr;
    logic [LW-1:0]     cmdLen;
    logic              cmdDone;
    logic [CW-1:0]     cmdDoneChanId;
    logic [N-1:0]      chStart;
    logic [N-1:0]      chDone;
    logic              grantErr;
    logic              doneErr;

    logic [AW-1:0] src_a [N];
    logic [AW-1:0] dst_a [N];
    logic [LW-1:0] len_a [N];

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 0;

    dma_grant_dispatcher #(
        .NO_OF_CHANNELS(N), .CID_WIDTH(CW), .ADDR_WIDTH(AW),
        .LEN_WIDTH(LW), .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock), .resetn(resetn), .chReq(chReq),
        .chSrcAddr(chSrcAddr), .chDstAddr(chDstAddr), .chLen(chLen),
        .arbReq(arbReq), .arbGrant(arbGrant), .arbGrantAck(arbGrantAck),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdChanId(cmdChanId),
        .cmdSrcAddr(cmdSrcAddr), .cmdDstAddr(cmdDstAddr), .cmdLen(cmdLen),
        .cmdDone(cmdDone), .cmdDoneChanId(cmdDoneChanId),
        .chStart(chStart), .chDone(chDone), .grantErr(grantErr), .doneErr(doneErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        chSrcAddr = '0;
        chDstAddr = '0;
        chLen     = '0;
        for (int i = 0; i < N; i++) begin
            chSrcAddr[i*AW +: AW] = src_a[i];
            chDstAddr[i*AW +: AW] = dst_a[i];
            chLen[i*LW +: LW]     = len_a[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: a queue of commands, a set of busy channels, and
    // the pulses the rules say must appear in the following cycle.
    typedef struct {
        int          cid;
        logic [31:0] src;
        logic [31:0] dst;
        logic [22:0] len;
    } cmd_t;

    cmd_t     m_q[$];
    bit [3:0] m_busy;
    bit [3:0] m_start, m_done, m_clr, m_set;
    bit       m_gerr, m_derr;
    bit       m_ack, m_pop;
    int       m_k;
    cmd_t     m_new;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_q.delete();
            m_busy  = '0;
            m_start = '0;
            m_done  = '0;
            m_gerr  = 0;
            m_derr  = 0;
        end else begin
            m_start = '0;
            m_done  = '0;
            m_clr   = '0;
            m_set   = '0;
            m_gerr  = 0;
            m_derr  = 0;
            m_ack   = (arbGrant != 0) && (m_q.size() < FD);
            m_pop   = (m_q.size() > 0) && cmdReady;
            if (cmdDone) begin
                if (int'(cmdDoneChanId) < N && m_busy[cmdDoneChanId]) begin
                    m_clr[cmdDoneChanId]  = 1;
                    m_done[cmdDoneChanId] = 1;
                end else begin
                    m_derr = 1;
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_ack) begin
                if ($countones(arbGrant) == 1) begin
                    m_k = 0;
                    for (int i = 0; i < N; i++) if (arbGrant[i]) m_k = i;
                    m_start[m_k] = 1;
                    if (len_a[m_k] == 0) begin
                        m_done[m_k] = 1;
                    end else begin
                        m_new.cid = m_k;
                        m_new.src = src_a[m_k];
                        m_new.dst = dst_a[m_k];
                        m_new.len = len_a[m_k];
                        m_q.push_back(m_new);
                        m_set[m_k] = 1;
                    end
                end else begin
                    m_gerr = 1;
                end
            end
            m_busy = (m_busy & ~m_clr) | m_set;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("arbReq", arbReq, chReq & ~m_busy & ~arbGrant);
            check("arbGrantAck", arbGrantAck, (arbGrant != 0) && (m_q.size() < FD));
            check("cmdValid", cmdValid, m_q.size() > 0);
            check("cmdChanId", cmdChanId, m_q.size() > 0 ? m_q[0].cid : 0);
            check("cmdSrcAddr", cmdSrcAddr, m_q.size() > 0 ? m_q[0].src : 0);
            check("cmdDstAddr", cmdDstAddr, m_q.size() > 0 ? m_q[0].dst : 0);
            check("cmdLen", cmdLen, m_q.size() > 0 ? m_q[0].len : 0);
            check("chStart", chStart, m_start);
            check("chDone", chDone, m_done);
            check("grantErr", grantErr, m_gerr);
            check("doneErr", doneErr, m_derr);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic done_pulse(input int id);
        cmdDone = 1;
        cmdDoneChanId = CW'(id);
        step();
        cmdDone = 0;
    endtask

    initial begin
        resetn = 0;
        chReq = 0;
        arbGrant = 0;
        cmdReady = 0;
        cmdDone = 0;
        cmdDoneChanId = 0;
        for (int i = 0; i < N; i++) begin
            src_a[i] = 32'h1000_0000 + 32'(i * 'h100);
            dst_a[i] = 32'h2000_0000 + 32'(i);
            len_a[i] = 23'(i + 1);
        end
        repeat (2) @(posedge clock);
        #1;
        resetn = 1;
        #1;
        check("rst_cmdValid", cmdValid, 0);
        check("rst_cmdChanId", cmdChanId, 0);
        check("rst_cmdSrcAddr", cmdSrcAddr, 0);
        check("rst_cmdLen", cmdLen, 0);
        check("rst_pulses", {chStart, chDone, grantErr, doneErr}, 0);
        cmp_en = 1;

        // 1: two channels, engine always ready
        chReq = 4'b0101;
        cmdReady = 1;
        #1;
        check("t1_arbReq", arbReq, 4'b0101);
        arbGrant = 4'b0001;
        #1;
        check("t1_ack", arbGrantAck, 1);
        step();
        arbGrant = 4'b0100;
        #1;
        check("t1_valid0", cmdValid, 1);
        check("t1_cid0", cmdChanId, 0);
        check("t1_src0", cmdSrcAddr, 32'h1000_0000);
        check("t1_start0", chStart, 4'b0001);
        step();
        arbGrant = 4'b0000;
        #1;
        check("t1_cid2", cmdChanId, 2);
        check("t1_len2", cmdLen, 3);
        check("t1_start2", chStart, 4'b0100);
        step();
        check("t1_empty", cmdValid, 0);
        check("t1_arbReq_end", arbReq, 4'b0000);
        done_pulse(0);
        done_pulse(2);
        chReq = 0;
        step();

        // 2: queue fills, third grant waits for a pop
        cmdReady = 0;
        chReq = 4'b1111;
        arbGrant = 4'b0001;
        step();
        arbGrant = 4'b0010;
        step();
        arbGrant = 4'b0100;
        #1;
        check("t2_full_ack", arbGrantAck, 0);
        step();
        check("t2_hold_ack", arbGrantAck, 0);
        check("t2_head0", cmdChanId, 0);
        cmdReady = 1;
        #1;
        check("t2_full_ready", arbGrantAck, 0);
        step();
        check("t2_ack_after_pop", arbGrantAck, 1);
        check("t2_head1", cmdChanId, 1);
        cmdReady = 0;
        step();
        arbGrant = 4'b0000;
        #1;
        check("t2_head1_stable", cmdChanId, 1);
        check("t2_start2", chStart, 4'b0100);
        cmdReady = 1;
        step();
        check("t2_head2", cmdChanId, 2);
        step();
        check("t2_empty", cmdValid, 0);
        check("t2_arbReq", arbReq, 4'b1000);

        // 3: completion and spurious completion
        done_pulse(1);
        check("t3_chDone1", chDone, 4'b0010);
        check("t3_arbReq", arbReq, 4'b1010);
        step();
        done_pulse(1);
        check("t3_doneErr", doneErr, 1);
        check("t3_no_chDone", chDone, 0);
        done_pulse(0);
        done_pulse(2);
        chReq = 0;
        step();

        // 4: zero-length descriptor
        len_a[3] = 0;
        chReq = 4'b1000;
        arbGrant = 4'b1000;
        step();
        arbGrant = 0;
        #1;
        check("t4_start", chStart, 4'b1000);
        check("t4_done", chDone, 4'b1000);
        check("t4_no_valid", cmdValid, 0);
        check("t4_arbReq", arbReq, 4'b1000);
        chReq = 0;
        len_a[3] = 4;
        step();

        // 5: bad grant, then reset with queued commands
        arbGrant = 4'b0011;
        #1;
        check("t5_ack", arbGrantAck, 1);
        step();
        arbGrant = 0;
        #1;
        check("t5_grantErr", grantErr, 1);
        check("t5_no_start", chStart, 0);
        check("t5_no_valid", cmdValid, 0);
        cmdReady = 0;
        chReq = 4'b0011;
        arbGrant = 4'b0001;
        step();
        arbGrant = 4'b0010;
        step();
        arbGrant = 0;
        #1;
        check("t5_queued", cmdValid, 1);
        #1;
        resetn = 0;
        #1;
        check("t5_rst_valid", cmdValid, 0);
        check("t5_rst_cid", cmdChanId, 0);
        check("t5_rst_arbReq", arbReq, 4'b0011);
        @(posedge clock);
        #1;
        resetn = 1;
        step();

        // set and spurious done on the same channel in one cycle
        chReq = 4'b0001;
        arbGrant = 4'b0001;
        cmdDone = 1;
        cmdDoneChanId = 0;
        step();
        arbGrant = 0;
        cmdDone = 0;
        #1;
        check("t6_start", chStart, 4'b0001);
        check("t6_doneErr", doneErr, 1);
        check("t6_no_chDone", chDone, 0);
        check("t6_valid", cmdValid, 1);
        cmdReady = 1;
        step();
        done_pulse(0);
        check("t6_chDone", chDone, 4'b0001);
        chReq = 0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
